temporal_spike_encoder: RTL



---
 rtl/temporal_enc_pkg.sv | 21 ++
 rtl/spike_line_cell.sv | 48 ++++
 rtl/temporal_spike_encoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/temporal_enc_pkg.sv
// Shared definitions for the temporal spike encoder.
//   enc_state_t  : window sequencing states (IDLE, RUN, FLUSH)
//   FLUSH_CNT_W  : width of the gamma-reset (flush) counter
//   DEFAULT_VAL_W: default value width; window length is 2**VAL_W cycles
//   maxv_of()    : the "no spike" value (2**VAL_W-1) for a given value width
package temporal_enc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } enc_state_t;

    localparam int FLUSH_CNT_W   = 8;
    localparam int DEFAULT_VAL_W = 6;

    function automatic int maxv_of(input int val_w);
        return (1 << val_w) - 1;
    endfunction

endpackage

// File: rtl/spike_line_cell.sv
// One spike line: holds the line's latched value and its sticky spike flop.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_load     : latch i_value and return the line high (window start)
//   i_value    : value for this line (spike time in cycles)
//   i_count    : shared window cycle counter
//   i_run      : encoder is in RUN
//   i_flush    : last RUN edge; line returns high
//   o_spike    : line output, idle 1, spike is a 1->0 edge
module spike_line_cell
    import temporal_enc_pkg::*;
#(
    parameter int VAL_W = DEFAULT_VAL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [VAL_W-1:0] i_value,
    input  logic [VAL_W-1:0] i_count,
    input  logic             i_run,
    input  logic             i_flush,
    output logic             o_spike
);

    localparam logic [VAL_W-1:0] MAXV = VAL_W'(maxv_of(VAL_W));

    logic [VAL_W-1:0] r_val;
    logic             r_spike;

    // Flush has priority over a match on the same edge so every line is
    // guaranteed high when gamma_rst asserts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val   <= '0;
            r_spike <= 1'b1;
        end else if (i_load) begin
            r_val   <= i_value;
            r_spike <= 1'b1;
        end else if (i_flush) begin
            r_spike <= 1'b1;
        end else if (i_run && (i_count == r_val) && (r_val != MAXV)) begin
            r_spike <= 1'b0;
        end
    end

    assign o_spike = r_spike;

endmodule

// File: rtl/temporal_spike_encoder.sv
// Edge-time spike encoder: each window, every line makes one 1->0 transition
// a number of cycles after window start equal to its value, then all lines
// return high and gamma_rst is pulsed for RST_CYCLES cycles.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : values_in carries a window vector
//   in_ready   : encoder can accept a vector (IDLE only)
//   values_in  : packed values, line i at [i*VAL_W +: VAL_W]
//   spikes_out : spike lines, idle high
//   busy       : high in RUN and FLUSH
//   gamma_rst  : downstream neuron reset, high during FLUSH
//   done       : one-cycle pulse when a window completes
module temporal_spike_encoder
    import temporal_enc_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int VAL_W      = DEFAULT_VAL_W,
    parameter int RST_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_LINES*VAL_W-1:0] values_in,
    output logic [NUM_LINES-1:0]       spikes_out,
    output logic                       busy,
    output logic                       gamma_rst,
    output logic                       done
);

    localparam logic [VAL_W-1:0]       MAXV       = VAL_W'(maxv_of(VAL_W));
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(RST_CYCLES - 1);

    enc_state_t             r_state, w_state_next;
    logic [VAL_W-1:0]       r_count, w_count_next;
    logic [FLUSH_CNT_W-1:0] r_fcnt, w_fcnt_next;
    logic                   r_in_ready, w_in_ready_next;
    logic                   r_busy, w_busy_next;
    logic                   r_gamma, w_gamma_next;
    logic                   r_done, w_done_next;
    logic                   w_load;
    logic                   w_run_end;
    logic                   w_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_fcnt     <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_gamma    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_fcnt     <= w_fcnt_next;
            r_in_ready <= w_in_ready_next;
            r_busy     <= w_busy_next;
            r_gamma    <= w_gamma_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_fcnt_next  = r_fcnt;
        w_gamma_next = 1'b0;
        w_done_next  = 1'b0;
        w_load       = 1'b0;
        w_run_end    = 1'b0;
        case (r_state)
            IDLE: begin
                // r_in_ready is low in the first cycle after reset, so no
                // vector is taken until in_ready is actually visible.
                if (in_valid && r_in_ready) begin
                    w_load       = 1'b1;
                    w_count_next = '0;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_count_next = r_count + 1'b1;
                if (r_count == MAXV) begin
                    w_run_end    = 1'b1;
                    w_gamma_next = 1'b1;
                    w_fcnt_next  = '0;
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                w_gamma_next = 1'b1;
                w_fcnt_next  = r_fcnt + 1'b1;
                if (r_fcnt == FLUSH_LAST) begin
                    w_gamma_next = 1'b0;
                    w_done_next  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        // Status outputs are registered from the next state so they line up
        // with the state register rather than lagging it by a cycle.
        w_in_ready_next = (w_state_next == IDLE);
        w_busy_next     = (w_state_next != IDLE);
    end

    assign w_run = (r_state == RUN);

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
            spike_line_cell #(
                .VAL_W (VAL_W)
            ) u_cell (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_load),
                .i_value (values_in[gi*VAL_W +: VAL_W]),
                .i_count (r_count),
                .i_run   (w_run),
                .i_flush (w_run_end),
                .o_spike (spikes_out[gi])
            );
        end
    endgenerate

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign gamma_rst = r_gamma;
    assign done      = r_done;

endmodule
